// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode bit indices, scheduler states and default latencies
package alu_pkg;

  localparam int ALU_SIG_W = 15;

  localparam int SIG_ADD  = 0;
  localparam int SIG_SUB  = 1;
  localparam int SIG_MUL  = 2;
  localparam int SIG_DIV  = 3;
  localparam int SIG_MOD  = 4;
  localparam int SIG_CMP  = 5;
  localparam int SIG_AND  = 6;
  localparam int SIG_OR   = 7;
  localparam int SIG_NOT  = 8;
  localparam int SIG_MOV  = 9;
  localparam int SIG_LSL  = 10;
  localparam int SIG_LSR  = 11;
  localparam int SIG_ASR  = 12;
  localparam int SIG_LDST = 13;

  localparam int DEF_MUL_LAT = 2;
  localparam int DEF_DIV_LAT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Divider latency wins over multiplier when both bits are set.
  function automatic logic [3:0] op_latency(input logic is_mul, input logic is_div,
                                            input logic is_mod, input logic [3:0] mul_lat,
                                            input logic [3:0] div_lat);
    if (is_div || is_mod) return div_lat;
    if (is_mul) return mul_lat;
    return 4'd1;
  endfunction

endpackage

// File: rtl/alu_sched_arb.sv
// rtl/alu_sched_arb.sv - 2-way round-robin arbiter for the shared ALU
module alu_sched_arb (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_valid
);

  assign grant_valid = |valid;
  assign grant_id    = (&valid) ? ~last_grant : valid[1];

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-requester scheduler in front of one multi-cycle ALU
// Optional macro ALU_SCHED_ONEHOT_CHECK_EN: reject non-one-hot opcodes with rsp_err.
module alu_sched
  import alu_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [31:0] req0_immx,
  input  logic        req0_isImmediate,
  input  logic [14:0] req0_aluSignals,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [31:0] req1_immx,
  input  logic        req1_isImmediate,
  input  logic [14:0] req1_aluSignals,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [31:0] alu_immx,
  output logic        alu_isImmediate,
  output logic [14:0] alu_aluSignals,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_flag,
  output logic        rsp_err
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        last_grant_q;
  logic [31:0] op1_q, op2_q, immx_q;
  logic        isimm_q;
  logic [14:0] sig_q;
  logic        rsp_id_q;
  logic [31:0] rsp_result_q;
  logic [1:0]  rsp_flag_q;

  logic        grant_id, grant_valid, accept;
  logic [31:0] g_op1, g_op2, g_immx;
  logic        g_isimm;
  logic [14:0] g_sig;
  logic [3:0]  g_lat;

  alu_sched_arb u_arb (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant_q),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign g_op1   = grant_id ? req1_op1 : req0_op1;
  assign g_op2   = grant_id ? req1_op2 : req0_op2;
  assign g_immx  = grant_id ? req1_immx : req0_immx;
  assign g_isimm = grant_id ? req1_isImmediate : req0_isImmediate;
  assign g_sig   = grant_id ? req1_aluSignals : req0_aluSignals;
  assign g_lat   = op_latency(g_sig[SIG_MUL], g_sig[SIG_DIV], g_sig[SIG_MOD],
                              4'(MUL_LAT), 4'(DIV_LAT));
  assign accept  = (state_q == IDLE) && grant_valid;

`ifdef ALU_SCHED_ONEHOT_CHECK_EN
  logic bad_sig;
  logic rsp_err_q;
  assign bad_sig = ~((g_sig != '0) && ((g_sig & (g_sig - 15'd1)) == '0));
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
`ifdef ALU_SCHED_ONEHOT_CHECK_EN
          state_d = bad_sig ? RESP : EXEC;
`else
          state_d = EXEC;
`endif
        end
      end
      EXEC:    if (cnt_q == 4'd1) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      op1_q        <= '0;
      op2_q        <= '0;
      immx_q       <= '0;
      isimm_q      <= 1'b0;
      sig_q        <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flag_q   <= '0;
`ifdef ALU_SCHED_ONEHOT_CHECK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        op1_q        <= g_op1;
        op2_q        <= g_op2;
        immx_q       <= g_immx;
        isimm_q      <= g_isimm;
        sig_q        <= g_sig;
        cnt_q        <= g_lat;
        last_grant_q <= grant_id;
        rsp_id_q     <= grant_id;
`ifdef ALU_SCHED_ONEHOT_CHECK_EN
        rsp_err_q    <= bad_sig;
        if (bad_sig) begin
          cnt_q        <= '0;
          rsp_result_q <= '0;
          rsp_flag_q   <= '0;
        end
`endif
      end else if (state_q == EXEC) begin
        cnt_q <= cnt_q - 4'd1;
        // Result is sampled on the final execute edge, then held through RESP.
        if (cnt_q == 4'd1) begin
          rsp_result_q <= alu_result;
          rsp_flag_q   <= alu_flag;
        end
      end
    end
  end

  assign req0_ready      = (state_q == IDLE);
  assign req1_ready      = (state_q == IDLE);
  assign alu_op1         = op1_q;
  assign alu_op2         = op2_q;
  assign alu_immx        = immx_q;
  assign alu_isImmediate = isimm_q;
  assign alu_aluSignals  = (state_q == EXEC) ? sig_q : '0;
  assign rsp_valid       = (state_q == RESP);
  assign rsp_id          = rsp_id_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_flag        = rsp_flag_q;

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - randomized self-checking bench for alu_sched with an ALU model
module tb_alu_sched;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_isImmediate;
  logic [31:0] req0_op1, req0_op2, req0_immx;
  logic [14:0] req0_aluSignals;
  logic        req1_valid, req1_ready, req1_isImmediate;
  logic [31:0] req1_op1, req1_op2, req1_immx;
  logic [14:0] req1_aluSignals;
  logic [31:0] alu_op1, alu_op2, alu_immx, alu_result;
  logic        alu_isImmediate;
  logic [14:0] alu_aluSignals;
  logic [1:0]  alu_flag;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_flag;

  int total = 0;
  int bad = 0;
  int last_model;

  logic [31:0] s_op1[2], s_op2[2], s_imm[2];
  logic        s_isimm[2];
  logic [14:0] s_sig[2];

  int          o_lat, o_sigcyc;
  logic        o_ready_seen, o_id, o_err;
  logic [31:0] o_res;
  logic [1:0]  o_flag;

  always #5 clk = ~clk;

  alu_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_immx(req0_immx), .req0_isImmediate(req0_isImmediate),
    .req0_aluSignals(req0_aluSignals),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_immx(req1_immx), .req1_isImmediate(req1_isImmediate),
    .req1_aluSignals(req1_aluSignals),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_immx(alu_immx),
    .alu_isImmediate(alu_isImmediate), .alu_aluSignals(alu_aluSignals),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag), .rsp_err(rsp_err)
  );

  // Reference arithmetic for one op, keyed by opcode kind (0 add .. 4 mod).
  function automatic logic [31:0] ref_result(input int kind, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (kind)
      0: return 32'(sa + sb);
      1: return 32'(sa - sb);
      2: return 32'(sa * sb);
      3: return (sb == 0) ? 32'd0 : 32'(sa / sb);
      4: return (sb == 0) ? 32'd0 : 32'(sa % sb);
      default: return a ^ b;
    endcase
  endfunction

  function automatic int kind_of(input logic [14:0] sig);
    for (int k = 0; k < 15; k++) if (sig[k]) return k;
    return 15;
  endfunction

  // Stand-in for the shared ALU driven by the scheduler.
  always_comb begin
    logic [31:0] r;
    r = ref_result(kind_of(alu_aluSignals), alu_op1, alu_isImmediate ? alu_immx : alu_op2);
    alu_result = r;
    alu_flag   = {r == 32'd0, r[31]};
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_op1 = 0; req0_op2 = 0; req0_immx = 0; req0_isImmediate = 0; req0_aluSignals = 0;
    req1_op1 = 0; req1_op2 = 0; req1_immx = 0; req1_isImmediate = 0; req1_aluSignals = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_model = 1;
    @(negedge clk);
  endtask

  task automatic load_req(input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic [14:0] sig);
    s_op1[n] = a; s_op2[n] = b; s_imm[n] = 32'h0; s_isimm[n] = 1'b0; s_sig[n] = sig;
  endtask

  // Present the staged ops, let one edge accept, then observe until rsp_valid.
  task automatic send(input logic [1:0] vmask);
    @(negedge clk);
    req0_op1 = s_op1[0]; req0_op2 = s_op2[0]; req0_immx = s_imm[0];
    req0_isImmediate = s_isimm[0]; req0_aluSignals = s_sig[0];
    req1_op1 = s_op1[1]; req1_op2 = s_op2[1]; req1_immx = s_imm[1];
    req1_isImmediate = s_isimm[1]; req1_aluSignals = s_sig[1];
    req0_valid = vmask[0]; req1_valid = vmask[1];
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    o_lat = 0; o_sigcyc = 0; o_ready_seen = 0;
    while (!rsp_valid && o_lat < 40) begin
      if (alu_aluSignals == s_sig[rsp_id] && alu_aluSignals != 0) o_sigcyc++;
      if (req0_ready || req1_ready) o_ready_seen = 1;
      @(posedge clk); #1;
      o_lat++;
    end
    if (req0_ready || req1_ready) o_ready_seen = 1;
    o_id = rsp_id; o_res = rsp_result; o_flag = rsp_flag; o_err = rsp_err;
  endtask

  task automatic consume();
    @(negedge clk);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b%b want 11", req1_ready, req0_ready);
    end
    total++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_rsp: valid=%b result=%h id=%b err=%b want 0", rsp_valid,
                      rsp_result, rsp_id, rsp_err);
    end
    total++;
    if (alu_aluSignals !== 15'd0 || alu_op1 !== 32'd0 || alu_op2 !== 32'd0) begin
      bad++; $display("FAIL reset_alu: sig=%h op1=%h op2=%h want 0", alu_aluSignals, alu_op1, alu_op2);
    end
  endtask

  task automatic test_add();
    load_req(0, 32'd5, 32'd3, 15'h0001);
    send(2'b01);
    total++;
    if (o_lat !== 1) begin bad++; $display("FAIL add_latency: got %0d want 1", o_lat); end
    total++;
    if (o_id !== 1'b0 || o_res !== 32'd8) begin
      bad++; $display("FAIL add_result: id=%b res=%0d want id=0 res=8", o_id, o_res);
    end
    total++;
    if (o_ready_seen !== 1'b0) begin bad++; $display("FAIL add_ready_busy: got 1 want 0"); end
    consume();
    last_model = 0;
  endtask

  task automatic test_div();
    load_req(1, 32'd15, 32'd3, 15'h0008);
    send(2'b10);
    total++;
    if (o_lat !== DIV_LAT) begin bad++; $display("FAIL div_latency: got %0d want %0d", o_lat, DIV_LAT); end
    total++;
    if (o_sigcyc !== DIV_LAT) begin
      bad++; $display("FAIL div_alu_signals: cycles=%0d want %0d", o_sigcyc, DIV_LAT);
    end
    total++;
    if (o_id !== 1'b1 || o_res !== 32'd5) begin
      bad++; $display("FAIL div_result: id=%b res=%0d want id=1 res=5", o_id, o_res);
    end
    total++;
    if (alu_aluSignals !== 15'd0) begin
      bad++; $display("FAIL div_resp_signals: got %h want 0", alu_aluSignals);
    end
    consume();
    last_model = 1;
  endtask

  task automatic test_contention();
    int cyc;
    logic exp_id;
    apply_reset();
    @(negedge clk);
    req0_op1 = 5; req0_op2 = 3; req0_immx = 0; req0_isImmediate = 0; req0_aluSignals = 15'h0004;
    req1_op1 = 5; req1_op2 = 3; req1_immx = 0; req1_isImmediate = 0; req1_aluSignals = 15'h0002;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc = 0;
      @(posedge clk); #1;
      while (!rsp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
      exp_id = ~last_model[0];
      last_model = int'(exp_id);
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== (exp_id ? 32'd2 : 32'd15)) begin
        bad++; $display("FAIL contention_%0d: valid=%b id=%b res=%0d want id=%b res=%0d", i,
                        rsp_valid, rsp_id, rsp_result, exp_id, exp_id ? 2 : 15);
      end
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
  endtask

  task automatic test_backpressure();
    logic        stable;
    logic [31:0] snap;
    load_req(0, 32'd7, 32'd9, 15'h0001);
    send(2'b01);
    snap = rsp_result;
    stable = 1;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_result !== snap || rsp_id !== 1'b0 || req0_ready || req1_ready)
        stable = 0;
    end
    total++;
    if (stable !== 1'b1 || snap !== 32'd16) begin
      bad++; $display("FAIL backpressure_hold: stable=%b res=%0d want stable=1 res=16", stable, snap);
    end
    consume();
    total++;
    if (rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin
      bad++; $display("FAIL backpressure_release: valid=%b ready=%b want 0 1", rsp_valid, req0_ready);
    end
    last_model = 0;
  endtask

  task automatic test_reset_mid_exec();
    logic seen;
    @(negedge clk);
    req1_op1 = 17; req1_op2 = 5; req1_aluSignals = 15'h0010; req1_isImmediate = 0;
    req1_valid = 1;
    @(posedge clk); #1;
    req1_valid = 0;
    @(posedge clk); #1;
    total++;
    if (alu_aluSignals !== 15'h0010) begin
      bad++; $display("FAIL midexec_signals: got %h want 0010", alu_aluSignals);
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    total++;
    if (alu_aluSignals !== 0 || alu_op1 !== 0 || alu_op2 !== 0 || rsp_valid !== 0 ||
        rsp_result !== 0 || rsp_id !== 0 || rsp_flag !== 0 || req0_ready !== 1) begin
      bad++; $display("FAIL midexec_reset: sig=%h op1=%h valid=%b res=%h id=%b want all 0",
                      alu_aluSignals, alu_op1, rsp_valid, rsp_result, rsp_id);
    end
    @(negedge clk);
    rst_n = 1;
    last_model = 1;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midexec_ghost_rsp: got 1 want 0"); end
    load_req(0, 32'd1, 32'd2, 15'h0001);
    send(2'b01);
    total++;
    if (o_res !== 32'd3 || o_lat !== 1 || o_id !== 1'b0) begin
      bad++; $display("FAIL midexec_next_op: res=%0d lat=%0d id=%b want 3 1 0", o_res, o_lat, o_id);
    end
    consume();
    last_model = 0;
  endtask

  task automatic test_onehot();
    load_req(0, 32'd6, 32'd4, 15'h0003);
    send(2'b01);
`ifdef ALU_SCHED_ONEHOT_CHECK_EN
    total++;
    if (o_err !== 1'b1 || o_res !== 32'd0 || o_flag !== 2'd0) begin
      bad++; $display("FAIL onehot_err: err=%b res=%h flag=%b want 1 0 0", o_err, o_res, o_flag);
    end
`else
    total++;
    if (o_err !== 1'b0 || o_lat !== 1) begin
      bad++; $display("FAIL onehot_noerr: err=%b lat=%0d want 0 1", o_err, o_lat);
    end
`endif
    consume();
    last_model = 0;
  endtask

  task automatic test_random();
    logic [1:0]  mask;
    int          kind[2], win, exp_lat, hold;
    logic [31:0] b, exp_res;
    for (int it = 0; it < 30; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int n = 0; n < 2; n++) begin
        kind[n]    = int'($urandom_range(0, 4));
        s_op1[n]   = 32'($urandom_range(0, 4000)) - 32'd2000;
        s_op2[n]   = 32'($urandom_range(1, 50));
        s_imm[n]   = 32'($urandom_range(1, 50)) - 32'd100;
        s_isimm[n] = 1'($urandom_range(0, 1));
        s_sig[n]   = 15'(1 << kind[n]);
      end
      win = (mask == 2'b11) ? 1 - last_model : (mask[1] ? 1 : 0);
      last_model = win;
      b = s_isimm[win] ? s_imm[win] : s_op2[win];
      exp_res = ref_result(kind[win], s_op1[win], b);
      exp_lat = (kind[win] >= 3) ? DIV_LAT : (kind[win] == 2) ? MUL_LAT : 1;
      send(mask);
      total++;
      if (o_id !== win[0] || o_res !== exp_res || o_flag !== {exp_res == 0, exp_res[31]}) begin
        bad++; $display("FAIL random_%0d_result: id=%b res=%h flag=%b want id=%0d res=%h", it,
                        o_id, o_res, o_flag, win, exp_res);
      end
      total++;
      if (o_lat !== exp_lat || o_sigcyc !== exp_lat || o_ready_seen !== 1'b0) begin
        bad++; $display("FAIL random_%0d_timing: lat=%0d sigcyc=%0d ready=%b want lat=%0d", it,
                        o_lat, o_sigcyc, o_ready_seen, exp_lat);
      end
      hold = int'($urandom_range(0, 3));
      repeat (hold) begin @(posedge clk); #1; end
      total++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp_res) begin
        bad++; $display("FAIL random_%0d_hold: valid=%b res=%h want 1 %h", it, rsp_valid,
                        rsp_result, exp_res);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_contention();
    test_backpressure();
    test_reset_mid_exec();
    test_onehot();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
